// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int unsigned PORT_C = 0;
  localparam int unsigned PORT_D = 1;

  localparam int unsigned MEM_BYTES_DEF = 300;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the port not granted last.
module rr_arbiter2
  import data_mem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,  // 1 = D was granted last
  output logic [1:0] o_grant
);

  logic w_c_turn;

  assign w_c_turn        = (i_last_grant == 1'(PORT_D));
  assign o_grant[PORT_C] = i_req[PORT_C] & (~i_req[PORT_D] | w_c_turn);
  assign o_grant[PORT_D] = i_req[PORT_D] & (~i_req[PORT_C] | ~w_c_turn);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data-memory port between core (C) and debug/DMA (D), sequencing
// IDLE -> ACCESS -> DONE with a one-cycle active-low strobe per access.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        c_req,
  input  logic        d_req,
  input  logic        c_we,
  input  logic        d_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] d_addr,
  input  logic [31:0] c_wdata,
  input  logic [31:0] d_wdata,
  output logic        c_ack,
  output logic        d_ack,
  output logic        c_err,
  output logic        d_err,
  output logic [31:0] c_rdata,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd_n,
  output logic        mem_wr_n,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [31:0] LastWord = 32'(MEM_BYTES - 4);

  state_e      r_state, w_state_next;
  logic        r_last_grant;
  logic        r_port;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic [1:0]  w_grant;
  logic        w_sel_d;
  logic [31:0] w_addr;

  rr_arbiter2 u_arb (
    .i_req        ({d_req, c_req}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_sel_d = w_grant[PORT_D];
  assign w_addr  = w_sel_d ? d_addr : c_addr;

  always_ff @(posedge CLK) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (|w_grant) w_state_next = ACCESS;
      ACCESS:  w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Payload is captured only on the grant edge; later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_last_grant <= 1'(PORT_D);
      r_port       <= 1'(PORT_C);
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else if (r_state == IDLE && |w_grant) begin
      r_last_grant <= w_sel_d;
      r_port       <= w_sel_d;
      r_we         <= w_sel_d ? d_we : c_we;
      r_wdata      <= w_sel_d ? d_wdata : c_wdata;
      r_addr       <= w_addr;
      r_err        <= (w_addr[1:0] != 2'b00) || (w_addr > LastWord);
    end else if (r_state == ACCESS) begin
      r_rdata <= (!r_we && !r_err) ? mem_rdata : 32'h0;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != IDLE);

  always_comb begin
    c_ack    = 1'b0;
    d_ack    = 1'b0;
    c_err    = 1'b0;
    d_err    = 1'b0;
    c_rdata  = '0;
    d_rdata  = '0;
    mem_rd_n = 1'b1;
    mem_wr_n = 1'b1;
    case (r_state)
      ACCESS: begin
        if (!r_err) begin
          if (r_we) mem_wr_n = 1'b0;
          else      mem_rd_n = 1'b0;
        end
      end
      DONE: begin
        if (r_port == 1'(PORT_D)) begin
          d_ack   = 1'b1;
          d_err   = r_err;
          d_rdata = r_rdata;
        end else begin
          c_ack   = 1'b1;
          c_err   = r_err;
          c_rdata = r_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a word-array memory model that commits on negedge.
module tb_data_mem_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        c_req, d_req, c_we, d_we;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic        c_ack, d_ack, c_err, d_err;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd_n, mem_wr_n, busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:74];
  logic        mem_clr;

  data_mem_arbiter #(.MEM_BYTES(300)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .c_req     (c_req),
    .d_req     (d_req),
    .c_we      (c_we),
    .d_we      (d_we),
    .c_addr    (c_addr),
    .d_addr    (d_addr),
    .c_wdata   (c_wdata),
    .d_wdata   (d_wdata),
    .c_ack     (c_ack),
    .d_ack     (d_ack),
    .c_err     (c_err),
    .d_err     (d_err),
    .c_rdata   (c_rdata),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd_n  (mem_rd_n),
    .mem_wr_n  (mem_wr_n),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = (mem_addr < 32'd300) ? mem[mem_addr[8:2]] : 32'h0;

  always @(negedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 75; i++) mem[i] <= 32'h0;
    end else if (!mem_wr_n && mem_addr < 32'd300) begin
      mem[mem_addr[8:2]] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        c_req; logic c_we; logic [31:0] c_addr; logic [31:0] c_wdata;
    logic        d_req; logic d_we; logic [31:0] d_addr; logic [31:0] d_wdata;
    logic        rd_n;  logic wr_n; logic [31:0] maddr;
    logic        c_ack; logic c_err; logic [31:0] c_rdata;
    logic        d_ack; logic d_err; logic [31:0] d_rdata;
  } vec_t;

  vec_t vt [11];

  initial begin
    int          ack_cyc[$];
    logic        ack_port[$];

    // Vectors assume last grant is D on entry (left so by the alternation run).
    vt[0]  = '{1,1,32'h10,32'hDEADBEEF, 0,0,0,0,   1,0,32'h10,  1,0,0,           0,0,0};
    vt[1]  = '{1,0,32'h10,0,            0,0,0,0,   0,1,32'h10,  1,0,32'hDEADBEEF,0,0,0};
    vt[2]  = '{0,0,0,0,  0+1,1,32'h20,32'h12345678, 1,0,32'h20, 0,0,0,          1,0,0};
    vt[3]  = '{1,0,32'h20,0,            1,0,32'h10,0, 0,1,32'h20, 1,0,32'h12345678,0,0,0};
    vt[4]  = '{1,0,32'h20,0,            1,0,32'h10,0, 0,1,32'h10, 0,0,0,          1,0,32'hDEADBEEF};
    vt[5]  = '{0,0,0,0,                 1,0,32'h12,0, 1,1,32'h12, 0,0,0,          1,1,0};
    vt[6]  = '{0,0,0,0,                 1,0,32'h12C,0,1,1,32'h12C,0,0,0,          1,1,0};
    vt[7]  = '{0,0,0,0,         1,1,32'h128,32'hA5A50F0F,1,0,32'h128,0,0,0,       1,0,0};
    vt[8]  = '{1,0,32'h128,0,           0,0,0,0,   0,1,32'h128, 1,0,32'hA5A50F0F,0,0,0};
    vt[9]  = '{1,1,32'h11,32'h55555555, 0,0,0,0,   1,1,32'h11,  1,1,0,           0,0,0};
    vt[10] = '{0,0,0,0,                 1,0,32'h10,0, 0,1,32'h10, 0,0,0,          1,0,32'hDEADBEEF};

    // Reset held with both ports requesting.
    Reset = 1'b0; mem_clr = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40; c_wdata = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ack_err_busy", {c_ack, d_ack, c_err, d_err, busy}, 0);
      chk("rst_strobes", {mem_rd_n, mem_wr_n}, 2'b11);
      chk("rst_rdata", c_rdata | d_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end
    mem_clr = 1'b0;
    Reset = 1'b1;

    // Continuous requests from both: grants alternate C, D, C, D every 3 cycles.
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) chk("first_grant_addr", mem_addr, 32'h40);
      if (c_ack) begin ack_cyc.push_back(n); ack_port.push_back(1'b0); end
      if (d_ack) begin ack_cyc.push_back(n); ack_port.push_back(1'b1); end
    end
    c_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < ack_cyc.size()) begin
        chk("rr_ack_port", ack_port[i], i % 2);
        chk("rr_ack_cycle", ack_cyc[i], 2 + 3 * i);
      end else begin
        chk("rr_ack_missing", 0, 1);
      end
    end
    chk("rr_ack_count", ack_cyc.size(), 4);
    tick();
    chk("rr_idle_busy", busy, 0);

    // Table-driven single transactions.
    for (int i = 0; i < 11; i++) begin
      c_req = vt[i].c_req; c_we = vt[i].c_we; c_addr = vt[i].c_addr; c_wdata = vt[i].c_wdata;
      d_req = vt[i].d_req; d_we = vt[i].d_we; d_addr = vt[i].d_addr; d_wdata = vt[i].d_wdata;
      tick();
      chk($sformatf("v%0d_acc_busy", i), busy, 1);
      chk($sformatf("v%0d_acc_strobes", i), {mem_rd_n, mem_wr_n}, {vt[i].rd_n, vt[i].wr_n});
      chk($sformatf("v%0d_acc_addr", i), mem_addr, vt[i].maddr);
      chk($sformatf("v%0d_acc_noack", i), {c_ack, d_ack}, 0);
      c_req = 1'b0; d_req = 1'b0;
      tick();
      chk($sformatf("v%0d_done_strobes", i), {mem_rd_n, mem_wr_n}, 2'b11);
      chk($sformatf("v%0d_c_ack_err", i), {c_ack, c_err}, {vt[i].c_ack, vt[i].c_err});
      chk($sformatf("v%0d_c_rdata", i), c_rdata, vt[i].c_rdata);
      chk($sformatf("v%0d_d_ack_err", i), {d_ack, d_err}, {vt[i].d_ack, vt[i].d_err});
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vt[i].d_rdata);
      tick();
      chk($sformatf("v%0d_idle", i), {busy, c_ack, d_ack}, 0);
    end

    // Payload and req changes after the grant are ignored.
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'h11112222;
    tick();
    c_req = 1'b0; c_addr = 32'h34; c_wdata = 32'h0;
    #1;
    chk("late_addr", mem_addr, 32'h30);
    chk("late_wdata", mem_wdata, 32'h11112222);
    chk("late_wr_n", mem_wr_n, 0);
    tick();
    chk("late_ack", c_ack, 1);
    tick();
    chk("late_ack_once", c_ack, 0);
    chk("late_mem30", mem[12], 32'h11112222);
    chk("late_mem34", mem[13], 32'h0);

    // Reset during ACCESS of a read aborts with no ack.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    tick();
    chk("abort_rd_n", mem_rd_n, 0);
    Reset = 1'b0; c_req = 1'b0;
    tick();
    chk("abort_state", {busy, c_ack, d_ack}, 0);
    chk("abort_strobes", {mem_rd_n, mem_wr_n}, 2'b11);
    Reset = 1'b1;
    tick();
    chk("abort_no_ack", {busy, c_ack, d_ack}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
